mac_lane_pipeline: RTL and testbench
====================================

// Module: mac_lane_pipeline
// PURPOSE
//  Parametrised, multi-lane signed MAC pipeline. It succeeds the single-lane fixed-width mac_pipeline.
//  Each lane computes y = base + a*b, where base is either an external acc operand or a per-lane
//  internal running accumulator. Adds valid/ready backpressure, saturate/wrap selection and per-lane
//  overflow flags. Sits between the operand fetch/broadcast logic and the result writeback of the compute array.
// PARAMETERS
//  N_LANES   4   number of independent MAC lanes
//  A_W       8   signed width of operand a
//  B_W       8   signed width of operand b
//  ACC_W     32  signed width of acc/y/internal accumulator; must be >= A_W+B_W (elaboration $error otherwise)
//  SATURATE  1   1: clamp on overflow; 0: two's-complement wrap
// PORTS
//  clk        in   1              clock, all logic on rising edge
//  rst_n      in   1              synchronous active-low reset
//  in_valid   in   1              input transaction valid
//  in_ready   out  1              block can accept; transfer when in_valid && in_ready
//  in_mode    in   1              0=MAC_EXT (base=in_acc), 1=MAC_INT (base=internal acc)
//  in_clr     in   1              MAC_INT only: base=0 for this transaction (starts new sum)
//  in_a       in   N_LANES*A_W    packed signed a, lane i at [i*A_W +: A_W]
//  in_b       in   N_LANES*B_W    packed signed b
//  in_acc     in   N_LANES*ACC_W  packed signed external base, ignored in MAC_INT
//  out_valid  out  1              result valid
//  out_ready  in   1              consumer accepts; transfer when out_valid && out_ready
//  out_y      out  N_LANES*ACC_W  packed signed results
//  out_ovf    out  N_LANES        per-lane overflow of this result (set in both SAT modes)
// BEHAVIOUR
//  - Synchronous reset is applied when rst_n=0 at a rising edge. It clears all stage valids,
//    out_valid=0, out_y=0, out_ovf=0 and every internal accumulator. in_ready=1 from the first edge after reset.
//  - Three stages share one advance enable: adv = !(out_valid && !out_ready). in_ready = adv.
//    - When adv=0, every stage register, including the internal accumulators, holds.
//    - There is no bubble collapse.
//  - S0 (input register): captures a, b, acc, mode, clr and valid on an accepting edge.
//  - S1: prod = a*b, full A_W+B_W signed, sign-extended to ACC_W. Mode, clr and acc pass through.
//  - S2 (output register): sum = base + prod, computed at ACC_W+1 bits.
//    - ovf = sum does not fit ACC_W.
//    - SATURATE=1: y = +max/-min on ovf. SATURATE=0: y = sum[ACC_W-1:0].
//  - Latency: a transaction accepted at edge k is presented with out_valid=1 after edge k+2.
//    Back-to-back input at out_ready=1 gives one result per cycle, in order.
//  - MAC_INT: the lane accumulator is written with the final (sat/wrapped) y at the edge that
//    loads S2 with a valid MAC_INT transaction.
//    - Consecutive INT transactions chain correctly, because the add and the update occur in the same stage.
//    - MAC_EXT transactions never modify the accumulator.
//    - in_clr is ignored in MAC_EXT.
//  - While out_valid=1 and out_ready=0, out_y and out_ovf are held stable.
//  - With in_valid=0, bubbles propagate. out_valid=0 when S2 holds a bubble, and out_y keeps its last value.
//  - Reset mid-stream discards all in-flight transactions: no out_valid is produced for them.
// STRUCTURE
//  - Package mac_pkg:
//    - typedef enum logic {MAC_EXT=1'b0, MAC_INT=1'b1} mac_mode_e
//    - function sat_add(...) returning {ovf, y}
//    - localparam defaults for A_W/B_W/ACC_W.
//  - Sub-module mac_lane: one lane's S1/S2 datapath plus accumulator, with an adv input.
//    It is instanced N_LANES times via generate. The top holds the valid/mode/clr pipeline,
//    the adv logic and the S0 capture.
// TESTING
//  T1: N_LANES=1, ACC_W=32, EXT, out_ready=1; (a,b,acc) = (3,4,10),(-2,7,5),(8,8,0) back-to-back
//      -> y=22,-9,64 on consecutive cycles. The first appears after accept edge+2. Exactly 3 outputs.
//  T2: INT; (2,3,clr=1),(4,5),(-1,6), then (1,1,clr=1) -> y=6,26,20,1; ovf=0 throughout.
//  T3: backpressure. Hold out_ready=0 for 4 cycles with 3 in flight
//      -> in_ready=0 while out_valid&&!out_ready; out_y stable. On release, 22,-9,64 in order,
//      no loss or duplication.
//  T4: ACC_W=16, SATURATE=1: acc=32767,a=1,b=1 -> y=32767,ovf=1; acc=-32768,a=-1,b=1 -> y=-32768,ovf=1.
//      SATURATE=0: first case -> y=-32768,ovf=1.
//  T5: N_LANES=4, EXT, lanes (1,1,0),(2,3,1),(ACC max,1,1),(-4,4,0), with ACC max = 2^(ACC_W-1)-1
//      -> y = 1, 7, +max (SAT), -16; out_ovf=4'b0100.
//  T6: INT sum at 26 with 2 in flight; rst_n=0 for one edge -> no out_valid for the 2.
//      Then INT (2,2,clr=0) -> y=4 (accumulator cleared by reset).

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and helpers for the multi-lane MAC pipeline.
// Holds the mode encoding, per-stage control record and the saturating add.
package mac_pkg;

  localparam int A_W_DEF   = 8;
  localparam int B_W_DEF   = 8;
  localparam int ACC_W_DEF = 32;
  localparam int MAX_W     = 64;

  typedef enum logic {MAC_EXT = 1'b0, MAC_INT = 1'b1} mac_mode_e;

  typedef struct packed {
    logic      vld;
    mac_mode_e mode;
    logic      clr;
  } meta_t;

  // Operands arrive sign-extended from acc_w (< MAX_W) bits, so the MAX_W sum never wraps.
  // Returns {ovf, y}; the caller keeps the low acc_w bits of y.
  function automatic logic [MAX_W:0] sat_add(input logic signed [MAX_W-1:0] base,
                                             input logic signed [MAX_W-1:0] prod,
                                             input int acc_w,
                                             input logic sat);
    logic signed [MAX_W-1:0] sum;
    logic signed [MAX_W-1:0] max_v;
    logic signed [MAX_W-1:0] min_v;
    logic signed [MAX_W-1:0] y;
    logic ovf;
    sum   = base + prod;
    max_v = (MAX_W'(1) <<< (acc_w - 1)) - MAX_W'(1);
    min_v = -max_v - MAX_W'(1);
    ovf   = (sum > max_v) || (sum < min_v);
    y     = (sat && ovf) ? (sum[MAX_W-1] ? min_v : max_v) : sum;
    return {ovf, y};
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: S1 product register, S2 add/saturate output register, running accumulator.
// Two cycles from S0 operands to y; every register holds while adv=0.
module mac_lane
  import mac_pkg::*;
#(
  parameter int A_W      = A_W_DEF,
  parameter int B_W      = B_W_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int SATURATE = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    adv,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  input  logic signed [ACC_W-1:0] acc,
  input  meta_t                   s1_meta,
  output logic signed [ACC_W-1:0] y,
  output logic                    ovf
);

  logic signed [A_W+B_W-1:0] prod_full;
  logic signed [ACC_W-1:0]   prod_s1;
  logic signed [ACC_W-1:0]   acc_s1;
  logic signed [ACC_W-1:0]   accum;
  logic signed [ACC_W-1:0]   base;
  logic [MAX_W:0]            res;
  logic                      unused_res_hi;

  assign prod_full = a * b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod_s1 <= '0;
      acc_s1  <= '0;
    end else if (adv) begin
      prod_s1 <= ACC_W'(prod_full);
      acc_s1  <= acc;
    end
  end

  // Base is read from the accumulator in the same stage that writes it, so INT chains need no bypass.
  always_comb begin
    base = acc_s1;
    if (s1_meta.mode == MAC_INT) base = s1_meta.clr ? '0 : accum;
  end

  assign res           = sat_add(MAX_W'(base), MAX_W'(prod_s1), ACC_W, SATURATE != 0);
  assign unused_res_hi = ^res[MAX_W-1:ACC_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y     <= '0;
      ovf   <= 1'b0;
      accum <= '0;
    end else if (adv && s1_meta.vld) begin
      y   <= res[ACC_W-1:0];
      ovf <= res[MAX_W];
      if (s1_meta.mode == MAC_INT) accum <= res[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/mac_lane_pipeline.sv
// N-lane signed MAC pipeline (y = base + a*b), result two edges after the accepting edge.
// Single advance enable: a stalled output freezes all stages and drops in_ready.
module mac_lane_pipeline
  import mac_pkg::*;
#(
  parameter int N_LANES  = 4,
  parameter int A_W      = A_W_DEF,
  parameter int B_W      = B_W_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int SATURATE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_mode,
  input  logic                     in_clr,
  input  logic [N_LANES*A_W-1:0]   in_a,
  input  logic [N_LANES*B_W-1:0]   in_b,
  input  logic [N_LANES*ACC_W-1:0] in_acc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_LANES*ACC_W-1:0] out_y,
  output logic [N_LANES-1:0]       out_ovf
);

  if (ACC_W < A_W + B_W) begin : g_bad_acc_w
    $error("mac_lane_pipeline: ACC_W must be >= A_W+B_W");
  end
  if (ACC_W > MAX_W - 1) begin : g_bad_max_w
    $error("mac_lane_pipeline: ACC_W exceeds sat_add range");
  end

  meta_t                    s0_meta;
  meta_t                    s1_meta;
  logic                     adv;
  logic [N_LANES*A_W-1:0]   a_s0;
  logic [N_LANES*B_W-1:0]   b_s0;
  logic [N_LANES*ACC_W-1:0] acc_s0;

  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_meta   <= '0;
      s1_meta   <= '0;
      out_valid <= 1'b0;
      a_s0      <= '0;
      b_s0      <= '0;
      acc_s0    <= '0;
    end else if (adv) begin
      s0_meta   <= '{vld: in_valid, mode: mac_mode_e'(in_mode), clr: in_clr};
      s1_meta   <= s0_meta;
      out_valid <= s1_meta.vld;
      if (in_valid) begin
        a_s0   <= in_a;
        b_s0   <= in_b;
        acc_s0 <= in_acc;
      end
    end
  end

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    mac_lane #(
      .A_W     (A_W),
      .B_W     (B_W),
      .ACC_W   (ACC_W),
      .SATURATE(SATURATE)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .adv    (adv),
      .a      (a_s0[g*A_W +: A_W]),
      .b      (b_s0[g*B_W +: B_W]),
      .acc    (acc_s0[g*ACC_W +: ACC_W]),
      .s1_meta(s1_meta),
      .y      (out_y[g*ACC_W +: ACC_W]),
      .ovf    (out_ovf[g])
    );
  end

endmodule

// File: tb/tb_mac_lane_pipeline.sv
// Directed bench: a 4-lane 32-bit saturating instance plus 1-lane 16-bit saturating/wrapping instances.
module tb_mac_lane_pipeline;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_mode;
  logic         in_clr;
  logic         out_ready;

  logic [31:0]  l4_a;
  logic [31:0]  l4_b;
  logic [127:0] l4_acc;
  logic         l4_in_ready;
  logic         l4_out_valid;
  logic [127:0] l4_out_y;
  logic [3:0]   l4_out_ovf;

  logic [7:0]   h_a;
  logic [7:0]   h_b;
  logic [15:0]  h_acc;
  logic         s_in_ready, s_out_valid, s_ovf;
  logic [15:0]  s_y;
  logic         w_in_ready, w_out_valid, w_ovf;
  logic [15:0]  w_y;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mac_lane_pipeline #(.N_LANES(4), .A_W(8), .B_W(8), .ACC_W(32), .SATURATE(1)) u_l4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(l4_in_ready),
    .in_mode(in_mode), .in_clr(in_clr), .in_a(l4_a), .in_b(l4_b), .in_acc(l4_acc),
    .out_valid(l4_out_valid), .out_ready(out_ready), .out_y(l4_out_y), .out_ovf(l4_out_ovf)
  );

  mac_lane_pipeline #(.N_LANES(1), .A_W(8), .B_W(8), .ACC_W(16), .SATURATE(1)) u_s16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_mode(in_mode), .in_clr(in_clr), .in_a(h_a), .in_b(h_b), .in_acc(h_acc),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_y(s_y), .out_ovf(s_ovf)
  );

  mac_lane_pipeline #(.N_LANES(1), .A_W(8), .B_W(8), .ACC_W(16), .SATURATE(0)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_mode(in_mode), .in_clr(in_clr), .in_a(h_a), .in_b(h_b), .in_acc(h_acc),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_y(w_y), .out_ovf(w_ovf)
  );

  task automatic drive_l0(input int a, input int b, input int acc, input logic mode, input logic clr);
    in_valid     = 1'b1;
    in_mode      = mode;
    in_clr       = clr;
    l4_a         = '0;
    l4_b         = '0;
    l4_acc       = '0;
    l4_a[7:0]    = 8'(a);
    l4_b[7:0]    = 8'(b);
    l4_acc[31:0] = acc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_clr = 1'b0; out_ready = 1'b1;
    l4_a = '0; l4_b = '0; l4_acc = '0; h_a = '0; h_b = '0; h_acc = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tests++; if (l4_out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b expected 0", l4_out_valid); end
    tests++; if (l4_out_y !== '0) begin fails++; $display("FAIL rst_y: got %h expected 0", l4_out_y); end
    tests++; if (l4_out_ovf !== 4'b0) begin fails++; $display("FAIL rst_ovf: got %b expected 0000", l4_out_ovf); end
    tests++; if ({s_out_valid, w_out_valid, s_y, w_y} !== '0) begin fails++; $display("FAIL rst_16: got %b %b %h %h expected zeros", s_out_valid, w_out_valid, s_y, w_y); end
    @(posedge clk); #1;
    tests++; if (l4_in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %b expected 1", l4_in_ready); end
  endtask

  task automatic test_ext_b2b();
    int a_t[3] = '{3, -2, 8};
    int b_t[3] = '{4, 7, 8};
    int c_t[3] = '{10, 5, 0};
    int y_t[3] = '{22, -9, 64};
    int n_out = 0;
    logic exp_v;
    for (int c = 0; c < 7; c++) begin
      if (c < 3) begin
        drive_l0(a_t[c], b_t[c], c_t[c], 1'b0, 1'b0);
        tests++; if (l4_in_ready !== 1'b1) begin fails++; $display("FAIL t1_in_ready%0d: got %b expected 1", c, l4_in_ready); end
      end else in_valid = 1'b0;
      @(posedge clk); #1;
      exp_v = (c >= 2 && c <= 4);
      tests++; if (l4_out_valid !== exp_v) begin fails++; $display("FAIL t1_valid%0d: got %b expected %b", c, l4_out_valid, exp_v); end
      if (exp_v) begin
        tests++; if (l4_out_y[31:0] !== y_t[c-2]) begin fails++; $display("FAIL t1_y%0d: got %0d expected %0d", c, $signed(l4_out_y[31:0]), y_t[c-2]); end
      end
      if (l4_out_valid === 1'b1) n_out++;
    end
    tests++; if (n_out != 3) begin fails++; $display("FAIL t1_count: got %0d expected 3", n_out); end
  endtask

  task automatic test_int_chain();
    int a_t[4]   = '{2, 4, -1, 1};
    int b_t[4]   = '{3, 5, 6, 1};
    logic k_t[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int y_t[4]   = '{6, 26, 20, 1};
    logic exp_v;
    for (int c = 0; c < 8; c++) begin
      if (c < 4) drive_l0(a_t[c], b_t[c], 999, 1'b1, k_t[c]);
      else in_valid = 1'b0;
      @(posedge clk); #1;
      exp_v = (c >= 2 && c <= 5);
      tests++; if (l4_out_valid !== exp_v) begin fails++; $display("FAIL t2_valid%0d: got %b expected %b", c, l4_out_valid, exp_v); end
      if (exp_v) begin
        tests++; if (l4_out_y[31:0] !== y_t[c-2]) begin fails++; $display("FAIL t2_y%0d: got %0d expected %0d", c, $signed(l4_out_y[31:0]), y_t[c-2]); end
        tests++; if (l4_out_ovf[0] !== 1'b0) begin fails++; $display("FAIL t2_ovf%0d: got %b expected 0", c, l4_out_ovf[0]); end
      end
    end
  endtask

  task automatic test_backpressure();
    int a_t[3] = '{3, -2, 8};
    int b_t[3] = '{4, 7, 8};
    int c_t[3] = '{10, 5, 0};
    int y_t[2] = '{-9, 64};
    for (int c = 0; c < 3; c++) begin
      drive_l0(a_t[c], b_t[c], c_t[c], 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    tests++; if (l4_in_ready !== 1'b0) begin fails++; $display("FAIL t3_stall_rdy: got %b expected 0", l4_in_ready); end
    for (int s = 0; s < 4; s++) begin
      @(posedge clk); #1;
      tests++; if (l4_in_ready !== 1'b0) begin fails++; $display("FAIL t3_rdy%0d: got %b expected 0", s, l4_in_ready); end
      tests++; if (l4_out_valid !== 1'b1 || l4_out_y[31:0] !== 32'd22) begin fails++; $display("FAIL t3_hold%0d: got v=%b y=%0d expected v=1 y=22", s, l4_out_valid, $signed(l4_out_y[31:0])); end
    end
    out_ready = 1'b1;
    #1;
    tests++; if (l4_in_ready !== 1'b1) begin fails++; $display("FAIL t3_release_rdy: got %b expected 1", l4_in_ready); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      tests++; if (l4_out_valid !== (k < 2)) begin fails++; $display("FAIL t3_valid%0d: got %b expected %b", k, l4_out_valid, (k < 2)); end
      if (k < 2) begin
        tests++; if (l4_out_y[31:0] !== y_t[k]) begin fails++; $display("FAIL t3_y%0d: got %0d expected %0d", k, $signed(l4_out_y[31:0]), y_t[k]); end
      end
    end
  endtask

  task automatic test_sat_wrap();
    int a_t[2]   = '{1, -1};
    int c_t[2]   = '{32767, -32768};
    int sy_t[2]  = '{32767, -32768};
    int wy_t[2]  = '{-32768, 32767};
    for (int c = 0; c < 5; c++) begin
      if (c < 2) begin
        in_valid = 1'b1; in_mode = 1'b0; in_clr = 1'b0;
        l4_a = '0; l4_b = '0; l4_acc = '0;
        h_a = 8'(a_t[c]); h_b = 8'd1; h_acc = 16'(c_t[c]);
      end else in_valid = 1'b0;
      @(posedge clk); #1;
      if (c >= 2 && c <= 3) begin
        tests++; if (s_out_valid !== 1'b1 || s_y !== 16'(sy_t[c-2]) || s_ovf !== 1'b1) begin
          fails++; $display("FAIL t4_sat%0d: got v=%b y=%0d ovf=%b expected v=1 y=%0d ovf=1", c-2, s_out_valid, $signed(s_y), s_ovf, sy_t[c-2]);
        end
        tests++; if (w_out_valid !== 1'b1 || w_y !== 16'(wy_t[c-2]) || w_ovf !== 1'b1) begin
          fails++; $display("FAIL t4_wrap%0d: got v=%b y=%0d ovf=%b expected v=1 y=%0d ovf=1", c-2, w_out_valid, $signed(w_y), w_ovf, wy_t[c-2]);
        end
      end
    end
    h_a = '0; h_b = '0; h_acc = '0;
  endtask

  task automatic test_multi_lane();
    logic [127:0] exp_y;
    logic exp_v;
    exp_y = {32'hFFFF_FFF0, 32'h7FFF_FFFF, 32'd7, 32'd1};
    for (int c = 0; c < 4; c++) begin
      if (c == 0) begin
        in_valid = 1'b1; in_mode = 1'b0; in_clr = 1'b1;
        l4_a   = {8'hFC, 8'd1, 8'd2, 8'd1};
        l4_b   = {8'd4, 8'd1, 8'd3, 8'd1};
        l4_acc = {32'd0, 32'h7FFF_FFFF, 32'd1, 32'd0};
      end else in_valid = 1'b0;
      @(posedge clk); #1;
      exp_v = (c == 2);
      tests++; if (l4_out_valid !== exp_v) begin fails++; $display("FAIL t5_valid%0d: got %b expected %b", c, l4_out_valid, exp_v); end
      if (exp_v) begin
        tests++; if (l4_out_y !== exp_y) begin fails++; $display("FAIL t5_y: got %h expected %h", l4_out_y, exp_y); end
        tests++; if (l4_out_ovf !== 4'b0100) begin fails++; $display("FAIL t5_ovf: got %b expected 0100", l4_out_ovf); end
      end
    end
  endtask

  task automatic test_reset_midstream();
    int a_t[4]   = '{2, 4, 1, 1};
    int b_t[4]   = '{3, 5, 1, 1};
    logic k_t[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic exp_v;
    for (int c = 0; c < 4; c++) begin
      drive_l0(a_t[c], b_t[c], 0, 1'b1, k_t[c]);
      @(posedge clk); #1;
    end
    tests++; if (l4_out_valid !== 1'b1 || l4_out_y[31:0] !== 32'd26) begin fails++; $display("FAIL t6_pre: got v=%b y=%0d expected v=1 y=26", l4_out_valid, $signed(l4_out_y[31:0])); end
    rst_n = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tests++; if (l4_out_valid !== 1'b0 || l4_out_y !== '0) begin fails++; $display("FAIL t6_rst: got v=%b y=%h expected v=0 y=0", l4_out_valid, l4_out_y); end
    for (int s = 0; s < 3; s++) begin
      @(posedge clk); #1;
      tests++; if (l4_out_valid !== 1'b0) begin fails++; $display("FAIL t6_flush%0d: got %b expected 0", s, l4_out_valid); end
    end
    for (int c = 0; c < 4; c++) begin
      if (c == 0) drive_l0(2, 2, 77, 1'b1, 1'b0);
      else in_valid = 1'b0;
      @(posedge clk); #1;
      exp_v = (c == 2);
      tests++; if (l4_out_valid !== exp_v) begin fails++; $display("FAIL t6_valid%0d: got %b expected %b", c, l4_out_valid, exp_v); end
      if (exp_v) begin
        tests++; if (l4_out_y[31:0] !== 32'd4) begin fails++; $display("FAIL t6_y: got %0d expected 4", $signed(l4_out_y[31:0])); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ext_b2b();
    test_int_chain();
    test_backpressure();
    test_sat_wrap();
    test_multi_lane();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
